// File: rtl/fp_align_ctrl_if.sv
// Bus between the FP-adder sequencer/counter side and the alignment controller.
interface fp_align_ctrl_if #(
  parameter int unsigned MANT_W = 24
);
  logic              start;
  logic [7:0]        exp_a;
  logic [7:0]        exp_b;
  logic [MANT_W-1:0] man_a;
  logic [MANT_W-1:0] man_b;
  logic              cnt_zero;
  logic [7:0]        cnt_value;
  logic              cnt_load;
  logic              cnt_down;
  logic [7:0]        exp_big;
  logic [MANT_W-1:0] man_big;
  logic [MANT_W+1:0] man_small;
  logic              sticky;
  logic              swapped;
  logic              busy;
  logic              done;

  // Requester plus down-counter side
  modport master (
    output start, exp_a, exp_b, man_a, man_b, cnt_zero,
    input  cnt_value, cnt_load, cnt_down, exp_big, man_big, man_small,
           sticky, swapped, busy, done
  );

  // Alignment controller side
  modport slave (
    input  start, exp_a, exp_b, man_a, man_b, cnt_zero,
    output cnt_value, cnt_load, cnt_down, exp_big, man_big, man_small,
           sticky, swapped, busy, done
  );
endinterface

// File: rtl/fp_align_ctrl.sv
// Exponent compare and mantissa alignment controller driving an external
// 8-bit down counter; shifts the smaller mantissa once per decrement.
module fp_align_ctrl #(
  parameter int unsigned MANT_W    = 24,
  parameter int unsigned MAX_SHIFT = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_align_ctrl_if.slave bus
);

  localparam int unsigned EW = 8;
  localparam int unsigned SW = MANT_W + 2;
  localparam logic [EW-1:0] MAX_SHIFT_E = EW'(MAX_SHIFT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [EW-1:0]     cnt_value_q;
  logic              cnt_load_q;
  logic              cnt_down_q;
  logic [EW-1:0]     exp_big_q;
  logic [MANT_W-1:0] man_big_q;
  logic [SW-1:0]     man_small_q;
  logic              sticky_q;
  logic              swapped_q;
  logic              busy_q;
  logic              done_q;
  logic [EW-1:0]     shift_cnt_q;

  logic              b_big_c;
  logic [EW-1:0]     diff_c;
  logic [EW-1:0]     clamp_c;
  logic              finish_c;

  // Operand compare and clamped exponent difference
  assign b_big_c = bus.exp_b > bus.exp_a;
  assign diff_c  = b_big_c ? (bus.exp_b - bus.exp_a) : (bus.exp_a - bus.exp_b);
  assign clamp_c = (diff_c > MAX_SHIFT_E) ? MAX_SHIFT_E : diff_c;

  // Local shift count guards against a counter that never reports zero
  assign finish_c = bus.cnt_zero || (shift_cnt_q >= cnt_value_q);

  // Alignment sequencer with registered strobes and results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt_value_q <= '0;
      cnt_load_q  <= 1'b0;
      cnt_down_q  <= 1'b0;
      exp_big_q   <= '0;
      man_big_q   <= '0;
      man_small_q <= '0;
      sticky_q    <= 1'b0;
      swapped_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_cnt_q <= '0;
    end else begin
      cnt_load_q <= 1'b0;
      cnt_down_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            swapped_q   <= b_big_c;
            exp_big_q   <= b_big_c ? bus.exp_b : bus.exp_a;
            man_big_q   <= b_big_c ? bus.man_b : bus.man_a;
            man_small_q <= {(b_big_c ? bus.man_a : bus.man_b), 2'b00};
            sticky_q    <= 1'b0;
            cnt_value_q <= clamp_c;
            shift_cnt_q <= '0;
            cnt_load_q  <= 1'b1;
            busy_q      <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (finish_c) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt_down_q <= 1'b1;
            state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          man_small_q <= {1'b0, man_small_q[SW-1:1]};
          sticky_q    <= sticky_q | man_small_q[0];
          shift_cnt_q <= shift_cnt_q + EW'(1);
          state       <= S_WAIT;
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cnt_value = cnt_value_q;
  assign bus.cnt_load  = cnt_load_q;
  assign bus.cnt_down  = cnt_down_q;
  assign bus.exp_big   = exp_big_q;
  assign bus.man_big   = man_big_q;
  assign bus.man_small = man_small_q;
  assign bus.sticky    = sticky_q;
  assign bus.swapped   = swapped_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Directed bench for fp_align_ctrl with a behavioural 8-bit down counter.
module tb_fp_align_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   force_one = 1'b0;
  bit   force_zero = 1'b0;
  int   total = 0;
  int   bad = 0;

  fp_align_ctrl_if #(.MANT_W(24)) bus ();

  fp_align_ctrl #(.MANT_W(24), .MAX_SHIFT(26)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Down counter: value on load/decrement edge, zero flag one edge later
  logic [7:0] cval;
  logic       zq;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cval <= 8'd0;
      zq   <= 1'b1;
    end else begin
      if (bus.cnt_load)      cval <= bus.cnt_value;
      else if (bus.cnt_down) cval <= cval - 8'd1;
      zq <= (cval == 8'd0);
    end
  end
  assign bus.cnt_zero = force_one ? 1'b1 : (force_zero ? 1'b0 : zq);

  typedef struct {
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
    logic        sw;
    logic [7:0]  ebig;
    logic [23:0] mbig;
    logic [7:0]  cv;
    logic [25:0] ms;
    logic        st;
    int          lat;
    int          downs;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL case%0d %s: got 0x%0h expected 0x%0h", id, nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input int id);
    check(id, "rst_busy",      32'(bus.busy), 32'd0);
    check(id, "rst_done",      32'(bus.done), 32'd0);
    check(id, "rst_strobes",   32'({bus.cnt_load, bus.cnt_down}), 32'd0);
    check(id, "rst_cnt_value", 32'(bus.cnt_value), 32'd0);
    check(id, "rst_exp_big",   32'(bus.exp_big), 32'd0);
    check(id, "rst_man_big",   32'(bus.man_big), 32'd0);
    check(id, "rst_man_small", 32'(bus.man_small), 32'd0);
    check(id, "rst_flags",     32'({bus.sticky, bus.swapped}), 32'd0);
  endtask

  // Runs one alignment from a start at the next edge; optionally pulses start in WAIT
  task automatic run_op(input int id, input vec_t v, input bit busy_start);
    int n;
    int downs;
    int loads;
    int clash;
    @(negedge clk);
    bus.exp_a = v.ea;
    bus.exp_b = v.eb;
    bus.man_a = v.ma;
    bus.man_b = v.mb;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0; downs = 0; loads = 0; clash = 0;
    while (!bus.done && n < 400) begin
      if (bus.cnt_load) loads++;
      if (bus.cnt_down) downs++;
      if (bus.cnt_load && bus.cnt_down) clash++;
      if (busy_start && n == 1) begin
        bus.exp_a = 8'd3;
        bus.exp_b = 8'd250;
        bus.man_a = 24'h123456;
        bus.man_b = 24'h654321;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check(id, "done_seen", 32'(bus.done), 32'd1);
    check(id, "latency",   32'(n), 32'(v.lat));
    check(id, "loads",     32'(loads), 32'd1);
    check(id, "downs",     32'(downs), 32'(v.downs));
    check(id, "clash",     32'(clash), 32'd0);
    check(id, "swapped",   32'(bus.swapped), 32'(v.sw));
    check(id, "exp_big",   32'(bus.exp_big), 32'(v.ebig));
    check(id, "man_big",   32'(bus.man_big), 32'(v.mbig));
    check(id, "cnt_value", 32'(bus.cnt_value), 32'(v.cv));
    check(id, "man_small", 32'(bus.man_small), 32'(v.ms));
    check(id, "sticky",    32'(bus.sticky), 32'(v.st));
    @(negedge clk);
    check(id, "done_pulse", 32'({bus.done, bus.busy}), 32'd0);
    check(id, "hold_man_small", 32'(bus.man_small), 32'(v.ms));
  endtask

  initial begin
    vec_t v;
    int n;
    int downs;
    int dones;
    //            ea     eb     ma          mb          sw    ebig   mbig        cv     ms            st    lat downs
    vecs[0] = '{8'd127, 8'd127, 24'h800000, 24'hC00000, 1'b0, 8'd127, 24'h800000, 8'd0,  26'h3000000, 1'b0, 3,  0};
    vecs[1] = '{8'd125, 8'd128, 24'h800007, 24'hA00000, 1'b1, 8'd128, 24'hA00000, 8'd3,  26'h0400003, 1'b1, 12, 3};
    vecs[2] = '{8'd200, 8'd10,  24'h900000, 24'hFFFFFF, 1'b0, 8'd200, 24'h900000, 8'd26, 26'h0000000, 1'b1, 81, 26};
    vecs[3] = '{8'd10,  8'd255, 24'h000000, 24'h812345, 1'b1, 8'd255, 24'h812345, 8'd26, 26'h0000000, 1'b0, 81, 26};
    vecs[4] = '{8'd101, 8'd100, 24'hFFFFFF, 24'h800001, 1'b0, 8'd101, 24'hFFFFFF, 8'd1,  26'h1000002, 1'b0, 6,  1};
    vecs[5] = '{8'd30,  8'd4,   24'hABCDEF, 24'h000001, 1'b0, 8'd30,  24'hABCDEF, 8'd26, 26'h0000000, 1'b1, 81, 26};
    vecs[6] = '{8'd0,   8'd27,  24'hFFFFFF, 24'h800000, 1'b1, 8'd27,  24'h800000, 8'd26, 26'h0000000, 1'b1, 81, 26};

    bus.start = 1'b0;
    bus.exp_a = 8'd0;
    bus.exp_b = 8'd0;
    bus.man_a = 24'd0;
    bus.man_b = 24'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero(100);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_op(i, vecs[i], 1'b0);

    // start pulsed during WAIT is ignored, next start in IDLE is accepted
    run_op(20, vecs[1], 1'b1);
    run_op(21, vecs[0], 1'b0);

    // Unexpected zero flag ends alignment at the first CHECK
    v = '{8'd105, 8'd100, 24'h800000, 24'hFFFFFF, 1'b0, 8'd105, 24'h800000, 8'd5, 26'h3FFFFFC, 1'b0, 3, 0};
    force_one = 1'b1;
    run_op(30, v, 1'b0);
    force_one = 1'b0;

    // Counter that never reports zero: shifts still bounded by cnt_value
    v = '{8'd50, 8'd52, 24'h800003, 24'h123456, 1'b1, 8'd52, 24'h123456, 8'd2, 26'h0800003, 1'b0, 9, 2};
    force_zero = 1'b1;
    run_op(31, v, 1'b0);
    force_zero = 1'b0;

    // Reset during the second SHIFT aborts with all outputs cleared
    @(negedge clk);
    bus.exp_a = 8'd130;
    bus.exp_b = 8'd128;
    bus.man_a = 24'h8AAAAA;
    bus.man_b = 24'hC55555;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0; downs = 0;
    while (downs < 2 && n < 50) begin
      if (bus.cnt_down) downs++;
      if (downs < 2) begin
        @(negedge clk);
        n++;
      end
    end
    check(40, "second_shift_reached", 32'(downs), 32'd2);
    rst_n = 1'b0;
    #1;
    check_all_zero(40);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check(40, "no_done_after_abort", 32'(dones), 32'd0);
    check_all_zero(41);

    // Operation after abort completes normally
    run_op(42, vecs[4], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
